// File: rtl/alu_pipe_hs.sv
// ============================================================================
// Module   : alu_pipe_hs
// Purpose  : Handshaked ALU with registered result, full flag set (Z/N/C/V),
//            signed/unsigned compare and a full-width multiply product.
//            Multiply is single-cycle (MUL_FAST=1) or iterative shift-add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe_hs #(
    parameter int WIDTH    = 32,
    parameter int MUL_FAST = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Sel,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] R_Hi,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Zflag,
    output logic             Nflag,
    output logic             Cflag,
    output logic             Vflag
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        mul_cnt;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     alu_lo;
    logic [WIDTH-1:0]     alu_hi;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   fast_prod;
    logic [2*WIDTH-1:0]   step_acc;
    logic                 accept;
    logic                 start_iter;

    // A single-cycle multiplier only exists when it is actually used.
    if (MUL_FAST != 0) begin : g_fast_mul
        assign fast_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    end else begin : g_iter_mul
        assign fast_prod = '0;
    end

    // Ready depends only on state and the consumer, never on In_Valid.
    assign In_Ready   = (state == IDLE) || ((state == DONE) && Out_Ready);
    assign accept     = In_Valid && In_Ready;
    assign start_iter = (Sel == OP_MUL) && (MUL_FAST == 0);

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign step_acc = acc + (mplier[0] ? mcand : {2*WIDTH{1'b0}});

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = A - B;

    // Single-cycle result and flag computation for the current opcode.
    always_comb begin
        alu_lo = '0;
        alu_hi = '0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case (Sel)
            OP_ADD: begin
                alu_lo = sum[WIDTH-1:0];
                alu_c  = sum[WIDTH];
                alu_v  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_lo = A & B;
            OP_OR:  alu_lo = A | B;
            OP_MUL: begin
                alu_lo = fast_prod[WIDTH-1:0];
                alu_hi = fast_prod[2*WIDTH-1:WIDTH];
                alu_c  = |fast_prod[2*WIDTH-1:WIDTH];
            end
            OP_SUB: begin
                alu_lo = diff;
                alu_c  = (A < B);
                alu_v  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_XOR:  alu_lo = A ^ B;
            default: alu_lo = '0;
        endcase
    end

    // Control FSM plus result/flag registers; an accept always takes priority.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            R         <= '0;
            R_Hi      <= '0;
            Out_Valid <= 1'b0;
            Zflag     <= 1'b0;
            Nflag     <= 1'b0;
            Cflag     <= 1'b0;
            Vflag     <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul_cnt   <= '0;
        end else if (accept) begin
            if (start_iter) begin
                acc       <= '0;
                mcand     <= {{WIDTH{1'b0}}, A};
                mplier    <= B;
                mul_cnt   <= CW'(WIDTH);
                state     <= BUSY;
                Out_Valid <= 1'b0;
            end else begin
                R         <= alu_lo;
                R_Hi      <= alu_hi;
                Zflag     <= (alu_lo == '0);
                Nflag     <= alu_lo[WIDTH-1];
                Cflag     <= alu_c;
                Vflag     <= alu_v;
                state     <= DONE;
                Out_Valid <= 1'b1;
            end
        end else begin
            case (state)
                BUSY: begin
                    acc     <= step_acc;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt - CW'(1);
                    if (mul_cnt == CW'(1)) begin
                        R         <= step_acc[WIDTH-1:0];
                        R_Hi      <= step_acc[2*WIDTH-1:WIDTH];
                        Zflag     <= (step_acc[WIDTH-1:0] == '0);
                        Nflag     <= step_acc[WIDTH-1];
                        Cflag     <= |step_acc[2*WIDTH-1:WIDTH];
                        Vflag     <= 1'b0;
                        state     <= DONE;
                        Out_Valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (Out_Ready) begin
                        state     <= IDLE;
                        Out_Valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_hs.sv
// ============================================================================
// Module   : tb_alu_pipe_hs
// Purpose  : Self-checking bench for alu_pipe_hs (WIDTH=8, iterative multiply)
//            using a result scoreboard plus per-scenario inline checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe_hs;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   Sel = '0;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [W-1:0] R;
    logic [W-1:0] R_Hi;
    logic         Out_Valid;
    logic         Out_Ready = 1'b0;
    logic         Zflag, Nflag, Cflag, Vflag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z, n, c, v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    alu_pipe_hs #(.WIDTH(W), .MUL_FAST(0)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .R         (R),
        .R_Hi      (R_Hi),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Zflag     (Zflag),
        .Nflag     (Nflag),
        .Cflag     (Cflag),
        .Vflag     (Vflag)
    );

    always #5 CLK = ~CLK;

    // Reference model built on integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        exp_t e;
        int sa, sbv, ua, ub, t;
        sa = $signed(a);
        sbv = $signed(b);
        ua = int'(a);
        ub = int'(b);
        e.lo = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0;
        case (s)
            3'd0: begin
                t = ua + ub;
                e.lo = t[W-1:0];
                e.c = (t > 255);
                e.v = ((sa + sbv) > 127) || ((sa + sbv) < -128);
            end
            3'd1: e.lo = a & b;
            3'd2: e.lo = a | b;
            3'd3: begin
                t = ua * ub;
                e.lo = t[7:0];
                e.hi = t[15:8];
                e.c = (t > 255);
            end
            3'd4: begin
                t = ua - ub;
                e.lo = t[W-1:0];
                e.c = (ua < ub);
                e.v = ((sa - sbv) > 127) || ((sa - sbv) < -128);
            end
            3'd5: e.lo = (sa < sbv) ? 8'd1 : 8'd0;
            3'd6: e.lo = (ua < ub) ? 8'd1 : 8'd0;
            default: e.lo = a ^ b;
        endcase
        e.z = (e.lo == 8'd0);
        e.n = e.lo[W-1];
        return e;
    endfunction

    // Scoreboard: every retired result must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST_N && Out_Valid && Out_Ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_result: got R=%h R_Hi=%h with no pending op", R, R_Hi);
            end else begin
                mon_e = sb.pop_front();
                if ({R, R_Hi, Zflag, Nflag, Cflag, Vflag} !==
                    {mon_e.lo, mon_e.hi, mon_e.z, mon_e.n, mon_e.c, mon_e.v}) begin
                    fails++;
                    $display("FAIL sb_result: got R=%h R_Hi=%h ZNCV=%b%b%b%b, expected R=%h R_Hi=%h ZNCV=%b%b%b%b",
                             R, R_Hi, Zflag, Nflag, Cflag, Vflag,
                             mon_e.lo, mon_e.hi, mon_e.z, mon_e.n, mon_e.c, mon_e.v);
                end
            end
        end
    end

    // Present one op and hold it until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        int n;
        A = a; B = b; Sel = s; In_Valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!In_Ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!In_Ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: In_Ready=%b after %0d cycles, expected 1", In_Ready, n);
        end
        sb.push_back(model(a, b, s));
        @(posedge CLK); #1;
        In_Valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        tests++;
        if ({Out_Valid, R, R_Hi, Zflag, Nflag, Cflag, Vflag} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: Out_Valid=%b R=%h R_Hi=%h ZNCV=%b%b%b%b, expected all 0",
                     Out_Valid, R, R_Hi, Zflag, Nflag, Cflag, Vflag);
        end
        tests++;
        if (In_Ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", In_Ready);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_add_flags();
        Out_Ready = 1'b1;
        send(8'hFF, 8'h01, 3'd0);
        tests++;
        if ({Out_Valid, R, Zflag, Cflag, Vflag, Nflag} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL add_carry: got OV=%b R=%h Z=%b C=%b V=%b N=%b, expected OV=1 R=00 Z=1 C=1 V=0 N=0",
                     Out_Valid, R, Zflag, Cflag, Vflag, Nflag);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_sub_slt();
        Out_Ready = 1'b1;
        send(8'h80, 8'h01, 3'd4);
        tests++;
        if ({R, Vflag, Cflag} !== {8'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sub_overflow: got R=%h V=%b C=%b, expected R=7f V=1 C=0", R, Vflag, Cflag);
        end
        send(8'h80, 8'h01, 3'd5);
        tests++;
        if (R !== 8'h01) begin
            fails++;
            $display("FAIL slt_signed: got R=%h expected 01", R);
        end
        send(8'h80, 8'h01, 3'd6);
        tests++;
        if ({R, Zflag} !== {8'h00, 1'b1}) begin
            fails++;
            $display("FAIL sltu_unsigned: got R=%h Z=%b expected R=00 Z=1", R, Zflag);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_mul_slow();
        Out_Ready = 1'b1;
        send(8'h10, 8'h20, 3'd3);
        for (int i = 0; i < W; i++) begin
            tests++;
            if (In_Ready !== 1'b0 || Out_Valid !== 1'b0) begin
                fails++;
                $display("FAIL mul_busy[%0d]: In_Ready=%b Out_Valid=%b, expected 0 0", i, In_Ready, Out_Valid);
            end
            @(posedge CLK); #1;
        end
        tests++;
        if ({Out_Valid, R_Hi, R, Zflag, Cflag} !== {1'b1, 8'h02, 8'h00, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL mul_result: got OV=%b R_Hi=%h R=%h Z=%b C=%b, expected OV=1 R_Hi=02 R=00 Z=1 C=1",
                     Out_Valid, R_Hi, R, Zflag, Cflag);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        Out_Ready = 1'b0;
        e = model(8'h12, 8'hF7, 3'd0);
        send(8'h12, 8'hF7, 3'd0);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({Out_Valid, In_Ready, R, Zflag, Nflag, Cflag, Vflag} !==
                {1'b1, 1'b0, e.lo, e.z, e.n, e.c, e.v}) begin
                fails++;
                $display("FAIL hold[%0d]: OV=%b IR=%b R=%h ZNCV=%b%b%b%b, expected OV=1 IR=0 R=%h ZNCV=%b%b%b%b",
                         i, Out_Valid, In_Ready, R, Zflag, Nflag, Cflag, Vflag, e.lo, e.z, e.n, e.c, e.v);
            end
            @(posedge CLK); #1;
        end
        Out_Ready = 1'b1;
        send(8'hF0, 8'h3C, 3'd1);
        tests++;
        if ({Out_Valid, R} !== {1'b1, 8'h30}) begin
            fails++;
            $display("FAIL retire_accept: got OV=%b R=%h expected OV=1 R=30", Out_Valid, R);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av[4];
        logic [W-1:0] bv[4];
        exp_t e;
        av = '{8'h01, 8'h10, 8'h7F, 8'hFF};
        bv = '{8'h02, 8'h20, 8'h01, 8'hFF};
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = model(av[i], bv[i], 3'd0);
            send(av[i], bv[i], 3'd0);
            tests++;
            if ({Out_Valid, R, Vflag} !== {1'b1, e.lo, e.v}) begin
                fails++;
                $display("FAIL b2b[%0d]: got OV=%b R=%h V=%b expected OV=1 R=%h V=%b",
                         i, Out_Valid, R, Vflag, e.lo, e.v);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_mul();
        Out_Ready = 1'b1;
        send(8'h05, 8'h07, 3'd3);
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        tests++;
        if ({Out_Valid, R, R_Hi, In_Ready} !== {1'b0, 8'h00, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL async_reset: OV=%b R=%h R_Hi=%h IR=%b, expected OV=0 R=00 R_Hi=00 IR=1",
                     Out_Valid, R, R_Hi, In_Ready);
        end
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            tests++;
            if (Out_Valid !== 1'b0) begin
                fails++;
                $display("FAIL stale_result[%0d]: Out_Valid=%b expected 0", i, Out_Valid);
            end
        end
        tests++;
        if (In_Ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready: got %b expected 1", In_Ready);
        end
        send(8'h03, 8'h04, 3'd7);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_flags();
        test_sub_slt();
        test_mul_slow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        @(negedge CLK);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_pipe_hs.md
Name: alu_pipe_hs

Overview:
- Parametrised, handshaked successor to the team's clocked 32-bit ALU.
- Accepts one operation per valid/ready transfer and returns a registered result plus full flag set (Z, N, C, V).
- Provides signed and unsigned compare, a full-width multiply product, and back-pressure on both sides.
- Sits between the operand/decode stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- MUL_FAST, 0, 1 = multiply completes in 1 cycle; 0 = iterative shift-add multiply taking WIDTH cycles in BUSY.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Sel  in  3  opcode.
- In_Valid  in  1  operands/opcode valid.
- In_Ready  out  1  block can accept an operation.
- R  out  WIDTH  result, low word.
- R_Hi  out  WIDTH  upper word of the multiply product; 0 for all other ops.
- Out_Valid  out  1  R/R_Hi/flags valid.
- Out_Ready  in  1  consumer takes result.
- Zflag  out  1  R == 0 (low word only).
- Nflag  out  1  R[WIDTH-1].
- Cflag  out  1  carry/borrow/high-word indicator.
- Vflag  out  1  signed overflow.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE.
  - R, R_Hi, Out_Valid, Zflag, Nflag, Cflag, Vflag = 0.
  - Multiply counter = 0.
  - In_Ready = 1 once in IDLE.
- Opcodes (A, B unsigned unless noted):
  - 000 add, R = A+B mod 2^WIDTH.
  - 001 and.
  - 010 or.
  - 011 mul, {R_Hi,R} = A*B as a 2*WIDTH unsigned product.
  - 100 sub, R = A-B mod 2^WIDTH.
  - 101 slt signed, R = 1 if $signed(A) < $signed(B), else 0.
  - 110 sltu, R = 1 if A < B, else 0.
  - 111 xor.
- Flags are registered together with R:
  - Zflag = (R == 0).
  - Nflag = R[WIDTH-1].
  - Cflag: add = carry out; sub = borrow (A < B unsigned); mul = (R_Hi != 0); all other ops 0.
  - Vflag: add/sub = signed overflow; all other ops 0.
- FSM states: IDLE, BUSY, DONE.
- In_Ready = (state == IDLE) || (state == DONE && Out_Ready). It is combinational from state and Out_Ready only, never from In_Valid.
- Accept: an operation is accepted on a rising edge where In_Valid && In_Ready. A, B and Sel are captured on that edge.
- Non-multiply ops, or mul with MUL_FAST = 1:
  - Result and flags are registered on the accept edge.
  - Next state is DONE and Out_Valid = 1 after that edge, giving 1-cycle latency.
- Mul with MUL_FAST = 0:
  - Accept edge loads the operands and sets counter = WIDTH; next state is BUSY.
  - Each BUSY edge does one shift-add step and decrements the counter.
  - On the edge where the counter reaches 0, the final product and flags are registered, next state is DONE, and Out_Valid = 1.
  - Out_Valid therefore rises WIDTH edges after the accept edge.
  - While in BUSY: In_Ready = 0 and Out_Valid = 0.
- DONE:
  - Out_Valid = 1.
  - R, R_Hi and flags are held stable while Out_Ready = 0.
  - Out_Ready = 1 with no new accept: next state is IDLE and Out_Valid = 0.
  - Out_Ready = 1 with In_Valid = 1 (simultaneous retire + accept): the new operation is accepted on the same edge, giving back-to-back throughput of 1 op/cycle for single-cycle ops.
- R, R_Hi and flags keep their last values in IDLE; only Out_Valid qualifies them.
- Reset mid-BUSY or mid-DONE aborts the operation: the pending result is lost and all outputs return to reset values.
- Sel changes while no transfer occurs are ignored.

Test Plan:
1. WIDTH=8. Reset, then accept add A=0xFF, B=0x01 -> one edge later Out_Valid=1, R=0x00, Zflag=1, Cflag=1, Vflag=0, Nflag=0.
2. WIDTH=8. sub A=0x80, B=0x01 -> R=0x7F, Vflag=1, Cflag=0. slt A=0x80, B=0x01 -> R=1. sltu with the same operands -> R=0.
3. WIDTH=8, MUL_FAST=0. mul A=0x10, B=0x20 -> In_Ready=0 for 8 cycles; Out_Valid rises 8 edges after accept with R_Hi=0x02, R=0x00, Zflag=1, Cflag=1.
4. Hold Out_Ready=0 for 5 cycles after a result -> R and flags remain unchanged and In_Ready=0. Then Out_Ready=1 together with In_Valid=1 for and 0xF0 & 0x3C -> next edge R=0x30, Out_Valid stays 1.
5. Stream 4 back-to-back add ops with Out_Ready held at 1 -> 4 results on 4 consecutive cycles, in order.
6. Assert RST_N low asynchronously 3 cycles into a MUL_FAST=0 multiply -> Out_Valid=0 and R=0 immediately without waiting for an edge; after release, In_Ready=1 and no stale result appears.
